// File: rtl/flappy_pkg.sv
// Shared types for the Flappy Bird game sequencer: state encoding,
// two-digit BCD score and its ordering helper.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam int BCD_MAX = 99;

  // Valid BCD digits order the same way as the packed byte, tens first.
  function automatic logic bcd2_gt(input bcd2_t a, input bcd2_t b);
    return {a.tens, a.ones} > {b.tens, b.ones};
  endfunction

endpackage

// File: rtl/flappy_game_ctrl_if.sv
// Game-control signal bundle between the sequencer (slave) and the rest of
// the game (master: buttons, collision detector, datapaths, display).
interface flappy_game_ctrl_if;
  logic       start_btn;
  logic       collide;
  logic       pipe_passed;
  logic       det_reset;
  logic       game_tick;
  logic       playing;
  logic       game_over;
  logic       flash;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic [3:0] best_tens;
  logic [3:0] best_ones;

  modport slave (
    input  start_btn, collide, pipe_passed,
    output det_reset, game_tick, playing, game_over, flash,
    output score_tens, score_ones, best_tens, best_ones
  );

  modport master (
    output start_btn, collide, pipe_passed,
    input  det_reset, game_tick, playing, game_over, flash,
    input  score_tens, score_ones, best_tens, best_ones
  );
endinterface

// File: rtl/bcd2_counter.sv
// Two-digit BCD up-counter with synchronous clear that sticks at 99.
module bcd2_counter
  import flappy_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_clr,
  input  logic  i_inc,
  output bcd2_t o_value
);

  bcd2_t r_val;
  logic  w_at_max;

  assign w_at_max = (r_val.tens == 4'(BCD_MAX / 10)) && (r_val.ones == 4'(BCD_MAX % 10));

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_val <= '0;
    end else if (i_inc && !w_at_max) begin
      if (r_val.ones == 4'd9) begin
        r_val.ones <= 4'd0;
        r_val.tens <= r_val.tens + 4'd1;
      end else begin
        r_val.ones <= r_val.ones + 4'd1;
      end
    end
  end

  assign o_value = r_val;

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game sequencer: Idle/Play/Dying/Over flow, scroll tick,
// Dying blink, current and best BCD scores, collision-detector reset.
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int TICK_DIV    = 12_500_000,
  parameter int FLASH_TICKS = 8
) (
  input  logic               clk,
  input  logic               reset,
  flappy_game_ctrl_if.slave  bus
);

  localparam int               CNT_W    = $clog2(TICK_DIV);
  localparam int               FC_W     = $clog2(FLASH_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [FC_W-1:0]  FC_INIT  = FC_W'(FLASH_TICKS);

  game_state_t      r_state, w_state_next;
  logic             r_start_q;
  logic [CNT_W-1:0] r_cnt;
  logic [FC_W-1:0]  r_flash_cnt;
  logic             r_flash;
  bcd2_t            r_best;
  bcd2_t            w_score;
  logic             w_start_rise, w_wrap, w_score_inc;
  logic             w_play_entry, w_dying_entry, w_over_entry;

  assign w_start_rise = bus.start_btn & ~r_start_q;
  assign w_wrap       = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_start_q <= bus.start_btn;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_play_entry  = 1'b0;
    w_dying_entry = 1'b0;
    w_over_entry  = 1'b0;
    case (r_state)
      IDLE, OVER: if (w_start_rise) begin
        w_state_next = PLAY;
        w_play_entry = 1'b1;
      end
      PLAY: if (bus.collide) begin
        w_state_next  = DYING;
        w_dying_entry = 1'b1;
      end
      DYING: if (w_wrap && r_flash_cnt == FC_W'(1)) begin
        w_state_next = OVER;
        w_over_entry = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Restarting the divider on Dying entry makes Dying exactly FLASH_TICKS full periods.
  always_ff @(posedge clk) begin
    if (reset || w_play_entry || w_dying_entry) begin
      r_cnt <= '0;
    end else if (r_state == PLAY || r_state == DYING) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_play_entry) begin
      r_flash     <= 1'b0;
      r_flash_cnt <= '0;
    end else if (w_dying_entry) begin
      r_flash_cnt <= FC_INIT;
    end else if (r_state == DYING && w_wrap) begin
      r_flash     <= ~r_flash;
      r_flash_cnt <= r_flash_cnt - FC_W'(1);
    end
  end

  // Collision wins over a simultaneous pipe pass.
  assign w_score_inc = (r_state == PLAY) && bus.pipe_passed && !bus.collide;

  bcd2_counter u_score (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_play_entry),
    .i_inc   (w_score_inc),
    .o_value (w_score)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_best <= '0;
    end else if (w_over_entry && bcd2_gt(w_score, r_best)) begin
      r_best <= w_score;
    end
  end

  assign bus.det_reset  = (r_state == IDLE) || (r_state == OVER);
  assign bus.game_tick  = (r_state == PLAY) && w_wrap;
  assign bus.playing    = (r_state == PLAY);
  assign bus.game_over  = (r_state == OVER);
  assign bus.flash      = r_flash;
  assign bus.score_tens = w_score.tens;
  assign bus.score_ones = w_score.ones;
  assign bus.best_tens  = r_best.tens;
  assign bus.best_ones  = r_best.ones;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl: a cycle-level game model in plain
// integers is compared against every output on each falling edge.
module tb_flappy_game_ctrl;

  localparam int TD = 4;
  localparam int FT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  flappy_game_ctrl_if bus();

  flappy_game_ctrl #(.TICK_DIV(TD), .FLASH_TICKS(FT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0=idle 1=play 2=dying 3=over; score/best kept as plain decimal.
  int m_st = 0, m_score = 0, m_best = 0, m_age = 0, m_flash_hold = 0;
  bit m_prev = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    bit rise;
    if (reset) begin
      m_st = 0; m_score = 0; m_best = 0; m_age = 0; m_flash_hold = 0; m_prev = 1'b0;
      m_valid = 1'b1;
    end else begin
      rise = bus.start_btn && !m_prev;
      m_prev = bus.start_btn;
      case (m_st)
        0, 3: if (rise) begin
          m_st = 1; m_score = 0; m_age = 0; m_flash_hold = 0;
        end
        1: if (bus.collide) begin
          m_st = 2; m_age = 0;
        end else begin
          if (bus.pipe_passed && m_score < 99) m_score++;
          m_age++;
        end
        default: if (m_age == FT * TD - 1) begin
          m_st = 3;
          if (m_score > m_best) m_best = m_score;
          m_flash_hold = FT % 2;
        end else begin
          m_age++;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("playing",   32'(bus.playing),   32'(m_st == 1));
      check("game_over", 32'(bus.game_over), 32'(m_st == 3));
      check("det_reset", 32'(bus.det_reset), 32'(m_st == 0 || m_st == 3));
      check("game_tick", 32'(bus.game_tick), 32'(m_st == 1 && (m_age % TD) == TD - 1));
      check("flash",     32'(bus.flash),     32'(m_st == 2 ? (m_age / TD) % 2 : m_flash_hold));
      check("score_tens", 32'(bus.score_tens), 32'(m_score / 10));
      check("score_ones", 32'(bus.score_ones), 32'(m_score % 10));
      check("best_tens",  32'(bus.best_tens),  32'(m_best / 10));
      check("best_ones",  32'(bus.best_ones),  32'(m_best % 10));
    end
  end

  task automatic pulses(input int n);
    repeat (n) begin
      @(negedge clk) bus.pipe_passed = 1'b1;
      @(negedge clk) bus.pipe_passed = 1'b0;
    end
  endtask

  task automatic start_press();
    @(negedge clk) bus.start_btn = 1'b1;
    @(negedge clk) bus.start_btn = 1'b0;
    check("lit_play_entry", 32'(bus.playing), 32'd1);
    check("lit_entry_score", 32'({bus.score_tens, bus.score_ones}), 32'h00);
  endtask

  task automatic die();
    @(negedge clk) bus.collide = 1'b1;
    @(negedge clk) bus.collide = 1'b0;
    repeat (FT * TD) @(negedge clk);
    check("lit_over", 32'(bus.game_over), 32'd1);
  endtask

  initial begin
    bus.start_btn = 1'b0;
    bus.collide = 1'b0;
    bus.pipe_passed = 1'b0;
    repeat (3) @(negedge clk);
    check("lit_rst_det", 32'(bus.det_reset), 32'd1);
    check("lit_rst_play", 32'(bus.playing), 32'd0);
    reset = 1'b0;

    // Start held high for 10 cycles: one entry, ticks on cycles 4 and 8.
    @(negedge clk) bus.start_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) check("lit_det_fall", 32'(bus.det_reset), 32'd0);
      if (k <= 8) check("lit_tick", 32'(bus.game_tick), 32'(k == 4 || k == 8));
    end
    bus.start_btn = 1'b0;
    $display("round1 entry: playing=%0d", bus.playing);

    pulses(7);
    check("lit_score07", 32'({bus.score_tens, bus.score_ones}), 32'h07);
    @(negedge clk) begin bus.collide = 1'b1; bus.pipe_passed = 1'b1; end
    @(negedge clk) begin bus.collide = 1'b0; bus.pipe_passed = 1'b0; end
    check("lit_dying_score", 32'({bus.score_tens, bus.score_ones}), 32'h07);
    check("lit_dying_tick", 32'(bus.game_tick), 32'd0);
    for (int k = 2; k <= 13; k++) begin
      @(negedge clk);
      if (k == 5) check("lit_flash_on", 32'(bus.flash), 32'd1);
      if (k == 9) check("lit_flash_off", 32'(bus.flash), 32'd0);
      if (k == 12) check("lit_not_over", 32'(bus.game_over), 32'd0);
    end
    check("lit_over1", 32'(bus.game_over), 32'd1);
    check("lit_best07", 32'({bus.best_tens, bus.best_ones}), 32'h07);
    $display("round1 over: best=%0d%0d", bus.best_tens, bus.best_ones);

    start_press();
    pulses(3);
    die();
    check("lit_best_keep", 32'({bus.best_tens, bus.best_ones}), 32'h07);
    $display("round2 over: best=%0d%0d", bus.best_tens, bus.best_ones);

    start_press();
    pulses(12);
    check("lit_score12", 32'({bus.score_tens, bus.score_ones}), 32'h12);
    pulses(93);
    check("lit_score99", 32'({bus.score_tens, bus.score_ones}), 32'h99);
    die();
    check("lit_best99", 32'({bus.best_tens, bus.best_ones}), 32'h99);
    $display("round3 over: best=%0d%0d", bus.best_tens, bus.best_ones);

    // Reset in the middle of Dying while the blink is on.
    start_press();
    pulses(1);
    @(negedge clk) bus.collide = 1'b1;
    @(negedge clk) bus.collide = 1'b0;
    repeat (5) @(negedge clk);
    check("lit_pre_rst_flash", 32'(bus.flash), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("lit_rstd_det", 32'(bus.det_reset), 32'd1);
    check("lit_rstd_flash", 32'(bus.flash), 32'd0);
    check("lit_rstd_best", 32'({bus.best_tens, bus.best_ones}), 32'h00);
    $display("reset in dying: flash=%0d best=%0d%0d", bus.flash, bus.best_tens, bus.best_ones);

    // Reset in the middle of Play at score 42.
    start_press();
    pulses(42);
    check("lit_score42", 32'({bus.score_tens, bus.score_ones}), 32'h42);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("lit_rstp_score", 32'({bus.score_tens, bus.score_ones}), 32'h00);
    check("lit_rstp_play", 32'(bus.playing), 32'd0);
    $display("reset in play: score=%0d%0d", bus.score_tens, bus.score_ones);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
